// File: rtl/pool_output_writer_pkg.sv
// pool_output_writer_pkg: shared defaults, window codes and FSM encoding for the pool output writer.
package pool_output_writer_pkg;
  localparam int DESIGN_SIZE_D = 4;
  localparam int DWIDTH_D = 8;
  localparam int AWIDTH_D = 10;
  localparam int MAX_BITS_POOL_D = 3;
  localparam int POOL_W1 = 1;
  localparam int POOL_W2 = 2;
  localparam int POOL_W4 = 4;
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
  function automatic logic [1:0] win_shift(input logic [7:0] w);
    return w == 8'(POOL_W4) ? 2'd2 : w == 8'(POOL_W2) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pool_output_writer_lane_packer.sv
// pool_lane_packer: steers the valid lanes of each beat into the next free slot of a pack word.
module pool_lane_packer
  import pool_output_writer_pkg::*;
#(
  parameter int DESIGN_SIZE = DESIGN_SIZE_D,
  parameter int DWIDTH = DWIDTH_D
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_clear,
  input  logic                          i_beat,
  input  logic [1:0]                    i_wsh,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] i_data,
  output logic [DESIGN_SIZE*DWIDTH-1:0] o_word,
  output logic                          o_word_valid,
  output logic                          o_partial
);
  localparam int LG = $clog2(DESIGN_SIZE);
  logic [DESIGN_SIZE*DWIDTH-1:0] r_pack;
  logic [1:0] r_fill, w_mask, w_fill_nx;
  assign w_mask = 2'((3'd1 << i_wsh) - 3'd1);
  assign w_fill_nx = (r_fill + 2'd1) & w_mask;
  assign o_word_valid = i_beat && r_fill == w_mask;
  assign o_partial = i_beat ? w_fill_nx != 2'd0 : r_fill != 2'd0;
  // o_word is the pack including the current beat, so a completing beat is written without an extra cycle
  always_comb begin
    o_word = r_pack;
    for (int j = 0; j < DESIGN_SIZE; j++)
      if (i_beat && 2'(j >> (LG - int'(i_wsh))) == r_fill)
        o_word[j*DWIDTH +: DWIDTH] = i_data[(j & ((DESIGN_SIZE >> i_wsh) - 1))*DWIDTH +: DWIDTH];
  end
  always_ff @(posedge clk)
    if (!reset || i_clear) begin
      r_pack <= '0;
      r_fill <= '0;
    end else if (i_beat) begin
      r_pack <= o_word_valid ? '0 : o_word;
      r_fill <= w_fill_nx;
    end
endmodule

// File: rtl/pool_output_writer.sv
// pool_output_writer: packs pool-stage rows into full words and writes them to BRAM with strided addressing.
module pool_output_writer
  import pool_output_writer_pkg::*;
#(
  parameter int DESIGN_SIZE = DESIGN_SIZE_D,
  parameter int DWIDTH = DWIDTH_D,
  parameter int AWIDTH = AWIDTH_D,
  parameter int MAX_BITS_POOL = MAX_BITS_POOL_D
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_writer,
  input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
  input  logic [AWIDTH-1:0]             start_addr,
  input  logic [AWIDTH-1:0]             addr_stride,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] in_data,
  input  logic                          in_data_available,
  input  logic                          in_done_pool,
  output logic [AWIDTH-1:0]             bram_addr,
  output logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata,
  output logic                          bram_we,
  output logic [15:0]                   words_written,
  output logic                          done_write
);
  state_t r_state, w_next;
  logic [1:0] r_wsh;
  logic [AWIDTH-1:0] r_cur_addr, r_stride, r_addr;
  logic [DESIGN_SIZE*DWIDTH-1:0] r_wdata, w_word;
  logic r_we;
  logic [15:0] r_words;
  logic w_beat, w_full, w_partial, w_start, w_sched;
  assign w_beat = r_state == COLLECT && in_data_available;
  assign w_start = r_state == IDLE && enable_writer;
  // the partial word is scheduled on the done cycle so it is written during FLUSH
  assign w_sched = enable_writer && r_state == COLLECT && (w_full || (in_done_pool && w_partial));
  assign bram_we = r_we && enable_writer;
  assign bram_addr = r_addr;
  assign bram_wdata = r_wdata;
  assign words_written = r_words;
  assign done_write = r_state == DONE;
  pool_lane_packer #(.DESIGN_SIZE(DESIGN_SIZE), .DWIDTH(DWIDTH)) u_packer (
    .clk(clk),
    .reset(reset),
    .i_clear(r_state != COLLECT || !enable_writer),
    .i_beat(w_beat),
    .i_wsh(r_wsh),
    .i_data(in_data),
    .o_word(w_word),
    .o_word_valid(w_full),
    .o_partial(w_partial)
  );
  always_comb begin
    w_next = r_state;
    if (!enable_writer) w_next = IDLE;
    else if (r_state == IDLE) w_next = COLLECT;
    else if (r_state == COLLECT) w_next = in_done_pool ? FLUSH : COLLECT;
    else if (r_state == FLUSH) w_next = DONE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= IDLE;
      r_wsh <= '0;
      r_cur_addr <= '0;
      r_stride <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_we <= 1'b0;
      r_words <= '0;
    end else begin
      r_state <= w_next;
      r_we <= w_sched;
      if (w_start) begin
        r_wsh <= win_shift(8'(pool_window_size));
        r_cur_addr <= start_addr;
        r_stride <= addr_stride;
        r_words <= '0;
      end
      if (w_sched) begin
        r_addr <= r_cur_addr;
        r_wdata <= w_word;
        r_cur_addr <= r_cur_addr + r_stride;
      end
      if (bram_we && r_words != 16'hFFFF) r_words <= r_words + 16'd1;
    end
endmodule

// File: tb/tb_pool_output_writer.sv
// tb_pool_output_writer: directed table, randomized jobs against a lane-queue model, abort and reset sequences.
module tb_pool_output_writer;
  localparam int DS = 4, DW = 8, AW = 10, MB = 3;
  typedef struct {
    int w;
    logic [AW-1:0] sa, st;
    bit dl;
    int nrows;
    logic [4:0][31:0] rows;
    int nexp;
    logic [4:0][AW+31:0] exp;
  } vec_t;
  logic clk = 0, reset = 0, enable_writer = 0, in_data_available = 0, in_done_pool = 0;
  logic [MB-1:0] pool_window_size = '0;
  logic [AW-1:0] start_addr = '0, addr_stride = '0, bram_addr;
  logic [31:0] in_data = '0, bram_wdata;
  logic bram_we, done_write;
  logic [15:0] words_written;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_cyc = 0;
  logic [AW+31:0] wq[$], exp_q[$];
  int wr_cyc[$];
  logic [31:0] rows_q[$];
  vec_t tv[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bram_we) begin
    wq.push_back({bram_addr, bram_wdata});
    wr_cyc.push_back(cyc);
  end

  pool_output_writer #(.DESIGN_SIZE(DS), .DWIDTH(DW), .AWIDTH(AW), .MAX_BITS_POOL(MB)) dut (
    .clk(clk), .reset(reset), .enable_writer(enable_writer), .pool_window_size(pool_window_size),
    .start_addr(start_addr), .addr_stride(addr_stride), .in_data(in_data),
    .in_data_available(in_data_available), .in_done_pool(in_done_pool), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_we(bram_we), .words_written(words_written), .done_write(done_write)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // reference: gather the valid lanes of every row in order, cut into DS-lane words, zero-pad the tail
  task automatic model(input int wraw, input logic [AW-1:0] sa, input logic [AW-1:0] st);
    int w = (wraw == 2 || wraw == 4) ? wraw : 1;
    logic [7:0] lanes[$];
    logic [AW-1:0] a = sa;
    exp_q.delete();
    foreach (rows_q[r]) for (int l = 0; l < DS / w; l++) lanes.push_back(rows_q[r][8*l +: 8]);
    while (lanes.size() > 0) begin
      logic [31:0] wd = '0;
      for (int l = 0; l < DS && lanes.size() > 0; l++) wd[8*l +: 8] = lanes.pop_front();
      exp_q.push_back({a, wd});
      a = a + st;
    end
  endtask

  task automatic run_job(input int w, input logic [AW-1:0] sa, input logic [AW-1:0] st, input bit dl, input bit gaps);
    int k = 0;
    wq.delete();
    wr_cyc.delete();
    pool_window_size = MB'(w);
    start_addr = sa;
    addr_stride = st;
    enable_writer = 1;
    tick();
    foreach (rows_q[i]) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        in_data_available = 0;
        in_data = $urandom;
        tick();
      end
      in_data = rows_q[i];
      in_data_available = 1;
      in_done_pool = dl && i == rows_q.size() - 1;
      last_cyc = cyc;
      tick();
    end
    in_data_available = 0;
    if (!in_done_pool) begin
      in_done_pool = 1;
      tick();
    end
    in_done_pool = 0;
    while (!done_write && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("done_write_set", 64'(done_write), 64'd1);
  endtask

  task automatic check_job(input string nm);
    chk({nm, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) chk({nm, "_write"}, 64'(wq[i]), 64'(exp_q[i]));
    chk({nm, "_words"}, 64'(words_written), 64'(exp_q.size()));
    enable_writer = 0;
    tick();
    chk({nm, "_done_clear"}, 64'(done_write), 64'd0);
    chk({nm, "_words_hold"}, 64'(words_written), 64'(exp_q.size()));
    tick();
  endtask

  initial begin
    tv[0] = '{1, 10'h010, 10'h001, 0, 2, {96'h0, 32'h08070605, 32'h04030201}, 2,
              {126'h0, {10'h011, 32'h08070605}, {10'h010, 32'h04030201}}};
    tv[1] = '{2, 10'h020, 10'h004, 0, 2, {96'h0, 32'h08070605, 32'h04030201}, 1,
              {168'h0, {10'h020, 32'h06050201}}};
    tv[2] = '{4, 10'h100, 10'h001, 1, 3, {64'h0, 32'hDEADBE33, 32'hDEADBE22, 32'hDEADBE11}, 1,
              {168'h0, {10'h100, 32'h00332211}}};
    tv[3] = '{3, 10'h3FE, 10'h001, 0, 5,
              {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 5,
              {{10'h002, 32'h55555555}, {10'h001, 32'h44444444}, {10'h000, 32'h33333333},
               {10'h3FF, 32'h22222222}, {10'h3FE, 32'h11111111}}};
    tv[4] = '{2, 10'h050, 10'h3F0, 0, 3, {64'h0, 32'h0C0B0A09, 32'h08070605, 32'h04030201}, 2,
              {126'h0, {10'h040, 32'h00000A09}, {10'h050, 32'h06050201}}};
    tv[5] = '{4, 10'h200, 10'h002, 1, 4, {32'h0, 32'hFFFFFF04, 32'hFFFFFF03, 32'hFFFFFF02, 32'hFFFFFF01}, 1,
              {168'h0, {10'h200, 32'h04030201}}};
    tick();
    tick();
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
    chk("rst_wdata", 64'(bram_wdata), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_done", 64'(done_write), 64'd0);
    reset = 1;
    tick();
    foreach (tv[v]) begin
      rows_q.delete();
      exp_q.delete();
      for (int r = 0; r < tv[v].nrows; r++) rows_q.push_back(tv[v].rows[r]);
      for (int e = 0; e < tv[v].nexp; e++) exp_q.push_back(tv[v].exp[e]);
      run_job(tv[v].w, tv[v].sa, tv[v].st, tv[v].dl, 0);
      if (v == 1) chk("w2_latency", 64'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 64'(last_cyc + 1));
      check_job($sformatf("vec%0d", v));
    end
    for (int j = 0; j < 12; j++) begin
      int w = $urandom_range(0, 7);
      int n = $urandom_range(0, 9);
      logic [AW-1:0] sa = AW'($urandom), st = AW'($urandom);
      rows_q.delete();
      for (int r = 0; r < n; r++) rows_q.push_back($urandom);
      model(w, sa, st);
      run_job(w, sa, st, n > 0 && $urandom_range(0, 1) == 1, 1);
      check_job($sformatf("rnd%0d", j));
    end
    // abort: enable drops in the cycle the completed word would be written
    wq.delete();
    pool_window_size = 3'd2;
    start_addr = 10'h030;
    addr_stride = 10'h001;
    enable_writer = 1;
    tick();
    in_data_available = 1;
    in_data = 32'h04030201;
    tick();
    in_data = 32'h08070605;
    tick();
    enable_writer = 0;
    in_data = 32'h0C0B0A09;
    @(negedge clk);
    chk("abort_we", 64'(bram_we), 64'd0);
    tick();
    in_data_available = 0;
    tick();
    tick();
    chk("abort_nwrites", 64'(wq.size()), 64'd0);
    chk("abort_done", 64'(done_write), 64'd0);
    rows_q = '{32'hA4A3A2A1};
    model(2, 10'h031, 10'h001);
    run_job(2, 10'h031, 10'h001, 0, 0);
    check_job("after_abort");
    // reset mid-collect with one half-row already packed
    pool_window_size = 3'd2;
    start_addr = 10'h077;
    addr_stride = 10'h005;
    enable_writer = 1;
    tick();
    in_data_available = 1;
    in_data = 32'h04030201;
    tick();
    in_data = 32'h08070605;
    tick();
    in_data = 32'h0C0B0A09;
    tick();
    in_data_available = 0;
    tick();
    chk("pre_rst_words", 64'(words_written), 64'd1);
    reset = 0;
    tick();
    reset = 1;
    chk("mid_rst_we", 64'(bram_we), 64'd0);
    chk("mid_rst_addr", 64'(bram_addr), 64'd0);
    chk("mid_rst_wdata", 64'(bram_wdata), 64'd0);
    chk("mid_rst_words", 64'(words_written), 64'd0);
    chk("mid_rst_done", 64'(done_write), 64'd0);
    enable_writer = 0;
    tick();
    rows_q = '{32'hB4B3B2B1};
    model(2, 10'h0C0, 10'h001);
    run_job(2, 10'h0C0, 10'h001, 1, 0);
    check_job("after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pool_output_writer.md
Name: pool_output_writer

Overview:
Consumer end of the pool output stream. Takes per-cycle rows from the pooling stage (data, available strobe, done), compacts the DESIGN_SIZE/window valid lanes of each row and packs them densely into full-width words. Writes each packed word to the output BRAM port with start-address/stride address generation. Sits between the pool stage and the output BRAM, and raises a completion flag for the top-level controller.

Parameters:
DESIGN_SIZE, 4, lanes per row (power of 2, >= 4)
DWIDTH, 8, bits per lane
AWIDTH, 10, BRAM address width
MAX_BITS_POOL, 3, width of pool window field

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
enable_writer  input  1  level; rising into 1 starts a job, 0 aborts/returns to idle
pool_window_size  input  MAX_BITS_POOL  1, 2 or 4; sampled at job start
start_addr  input  AWIDTH  first write address; sampled at job start
addr_stride  input  AWIDTH  address increment per written word; sampled at job start
in_data  input  DESIGN_SIZE*DWIDTH  pool output row, lane 0 at LSBs
in_data_available  input  1  in_data valid this cycle (no backpressure)
in_done_pool  input  1  level; pool stage has finished producing rows
bram_addr  output  AWIDTH  write address
bram_wdata  output  DESIGN_SIZE*DWIDTH  packed word
bram_we  output  1  write strobe, one cycle per word
words_written  output  16  count of words written in the current job
done_write  output  1  level; job complete, held until enable_writer=0

Behaviour:
- Reset (reset=0 at posedge): state IDLE; bram_addr=0, bram_wdata=0, bram_we=0, words_written=0, done_write=0. Pack register, fill count and address register cleared.
- Window decode: W = pool_window_size when it is 1, 2 or 4. Any other value is treated as 1. N = DESIGN_SIZE/W lanes valid per beat. Only lanes 0..N-1 of in_data are used.
- FSM: IDLE -> COLLECT when enable_writer=1. Entering COLLECT latches W, start_addr into cur_addr, and addr_stride; clears fill_cnt and words_written.
- In COLLECT, each cycle with in_data_available=1:
  - copy lanes 0..N-1 into pack lanes fill_cnt*N .. fill_cnt*N+N-1;
  - fill_cnt = (fill_cnt+1) mod W.
- Word complete (beat arrives with fill_cnt==W-1): the completed word is captured into an output register. The next cycle drives bram_we=1, bram_addr=cur_addr, bram_wdata=word. Then cur_addr += addr_stride (modulo 2^AWIDTH, wrap silent) and words_written += 1 (saturates at 0xFFFF).
- Write latency is 1 cycle after the completing beat. The pack register is cleared on completion, so a beat every cycle is sustained with no loss.
- COLLECT -> FLUSH when in_done_pool=1. A beat in the same cycle is accepted first.
- FLUSH, one cycle:
  - if fill_cnt!=0, write the partial word with unfilled lanes zero, in the cycle after FLUSH entry, using the same addressing;
  - a full word completed on the done cycle is written normally, and the partial is not issued;
  - if fill_cnt==0, no write.
  - Then go to DONE.
- DONE: done_write=1, bram_we=0, in_data_available ignored. DONE -> IDLE when enable_writer=0; done_write clears and words_written holds.
- enable_writer=0 in COLLECT/FLUSH: go to IDLE next cycle. A write already scheduled for that cycle is suppressed (bram_we=0), partial data is discarded, and done_write stays 0.
- in_data_available in IDLE: ignored.
- reset=0 mid-job: full reset as above, and any pending write is dropped.
- bram_addr/bram_wdata hold their last values when bram_we=0.

Decomposition:
- Shared package: window decode constants (POOL_W1/W2/W4), FSM state encoding (IDLE, COLLECT, FLUSH, DONE), DESIGN_SIZE/DWIDTH/AWIDTH defaults, which match the existing global defines.
- One sub-module is natural: pool_lane_packer. It holds the pack register, fill_cnt and lane-slot steering, and outputs word_valid/word/partial. The top holds the FSM, address generation and counters.

Test Plan:
- W=1, start_addr=0x010, stride=1, rows 0x04030201, 0x08070605, then done. Required: writes 0x04030201@0x010 and 0x08070605@0x011; done_write=1; words_written=2.
- W=2, start=0x020, stride=4, rows 0x04030201, 0x08070605 back-to-back. Required: one write 0x06050201@0x020, issued one cycle after the second beat.
- W=4, rows 0x..11, 0x..22, 0x..33, then in_done_pool. Required: partial write 0x00332211; words_written=1.
- W=3 (unsupported), 5 continuous rows, start=0x3FE, stride=1. Required: pass-through writes at addresses 0x3FE, 0x3FF, 0x000, 0x001, 0x002.
- W=2, three beats, then enable_writer=0 in the same cycle the 2nd-beat write is scheduled. Required: no write issued, return to IDLE, done_write=0. A new job then starts clean.
- reset=0 for 1 cycle mid-COLLECT with fill_cnt=1. Required: all outputs 0 next cycle; no stale partial written after restart.
